operand_issue: RTL and testbench

//   Decode-side driver of the ALU operand interface. On entry to decode (stage 2) it

---
 rtl/operand_issue_pkg.sv | 37 +++
 rtl/operand_issue_imm_gen.sv | 22 ++
 rtl/operand_issue.sv | 205 ++++++++++++++++++++
 tb/tb_operand_issue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_issue_pkg.sv
// Shared constants and types for the decode-side operand issuer:
// instruction format codes, the opcode/funct3 values the operand map
// depends on, and the immediate bundle produced by the immediate generator.
package operand_issue_pkg;

  // Instruction format codes carried on itype_i
  localparam logic [4:0] IT_RTYPE  = 5'd0;
  localparam logic [4:0] IT_ITYPE  = 5'd1;
  localparam logic [4:0] IT_LTYPE  = 5'd2;
  localparam logic [4:0] IT_STYPE  = 5'd3;
  localparam logic [4:0] IT_BTYPE  = 5'd4;
  localparam logic [4:0] IT_UTYPE  = 5'd5;
  localparam logic [4:0] IT_JRTYPE = 5'd6;

  // Opcodes that split the U format into LUI / AUIPC
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Shift-immediate funct3 values: b is the 5-bit shamt, not the I immediate
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  // All immediates, already sign-extended to 32 bits
  typedef struct packed {
    logic [31:0] i;
    logic [31:0] s;
    logic [31:0] b;
    logic [31:0] u;
  } imm_t;

  // Formats whose pass operand is consumed by the ALU (store data, branch
  // offset, link address) and therefore get a readin_pass strobe
  function automatic logic itype_uses_pass(input logic [4:0] it);
    return (it == IT_STYPE) || (it == IT_BTYPE) || (it == IT_JRTYPE);
  endfunction

endpackage

// File: rtl/operand_issue_imm_gen.sv
// Combinational immediate generator: instruction word -> I/S/B/U immediates,
// each sign-extended to 32 bits. Opcode bits are not part of any immediate.
module operand_issue_imm_gen
  import operand_issue_pkg::*;
(
  input  logic [31:0] i_ir,
  output imm_t        o_imm
);

  logic w_unused_opcode;

  // Field scatter for each format
  always_comb begin
    o_imm.i = {{20{i_ir[31]}}, i_ir[31:20]};
    o_imm.s = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
    o_imm.b = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
    o_imm.u = {i_ir[31:12], 12'b0};
  end

  assign w_unused_opcode = ^i_ir[6:0];

endmodule

// File: rtl/operand_issue.sv
// Decode-side ALU operand driver. On the entry edge into the decode stage it
// samples IR/format/PC, reads rs1/rs2 from the synchronous regfile, builds the
// a/b/pass operands, gives the ALU one setup cycle and then pulses the
// readin_* latch strobes for one cycle, followed by a done pulse.
//
// Build option: define ISSUE_FWD_EN to let a same-cycle writeback
// (wb_we_i/wb_rd_i/wb_data_i) override the regfile data during RD.
//
// Handshake: there is no backpressure. A start (stage_i entering DECODE_ST
// while idle) always runs to completion; readd_* are stable from the SETUP
// cycle onward, readin_* are high for exactly one cycle, and done_o/err_o
// are single-cycle pulses. Starts seen while busy are dropped.
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter logic [2:0] DECODE_ST = 3'd2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      stage_i,
  input  logic [31:0]     ir_i,
  input  logic [4:0]      itype_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] readd_a_o,
  output logic [XLEN-1:0] readd_b_o,
  output logic [XLEN-1:0] readd_pass_o,
  output logic            readin_a_o,
  output logic            readin_b_o,
  output logic            readin_pass_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [2:0]      dbg_state_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]      r_state;
  logic [2:0]      r_stage;
  logic [31:0]     r_ir;
  logic [4:0]      r_itype;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_a, r_b, r_pass;
  logic            r_rd_a, r_rd_b, r_rd_pass;
  logic            r_done, r_err;

  logic            w_start;
  logic [XLEN-1:0] w_rs1, w_rs2;
  logic [XLEN-1:0] w_a, w_b, w_pass;
  logic            w_known;
  imm_t            w_imm;

  operand_issue_imm_gen u_imm_gen (
    .i_ir  (r_ir),
    .o_imm (w_imm)
  );

  // Regfile addresses follow the live IR so the sync read lands in RD
  assign rs1_addr_o = ir_i[19:15];
  assign rs2_addr_o = ir_i[24:20];

  assign w_start = (stage_i == DECODE_ST) && (r_stage != DECODE_ST) && (r_state == ST_IDLE);

  // Source operand selection: optional writeback bypass, x0 always reads zero
  always_comb begin
    w_rs1 = rs1_data_i;
    w_rs2 = rs2_data_i;
`ifdef ISSUE_FWD_EN
    if (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == r_ir[19:15])) w_rs1 = wb_data_i;
    if (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == r_ir[24:20])) w_rs2 = wb_data_i;
`endif
    if (r_ir[19:15] == 5'd0) w_rs1 = '0;
    if (r_ir[24:20] == 5'd0) w_rs2 = '0;
  end

`ifndef ISSUE_FWD_EN
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_we_i, wb_rd_i, wb_data_i};
`endif

  // Per-format operand map from the held instruction
  always_comb begin
    w_a     = '0;
    w_b     = '0;
    w_pass  = '0;
    w_known = 1'b1;
    case (r_itype)
      IT_RTYPE: begin
        w_a = w_rs1;
        w_b = w_rs2;
      end
      IT_ITYPE: begin
        w_a = w_rs1;
        if ((r_ir[14:12] == F3_SLLI) || (r_ir[14:12] == F3_SRXI)) w_b = {27'b0, r_ir[24:20]};
        else                                                    w_b = w_imm.i;
      end
      IT_LTYPE: begin
        w_a = w_rs1;
        w_b = w_imm.i;
      end
      IT_STYPE: begin
        w_a    = w_rs1;
        w_b    = w_imm.s;
        w_pass = w_rs2;
      end
      IT_BTYPE: begin
        w_a    = w_rs1;
        w_b    = w_rs2;
        w_pass = w_imm.b;
      end
      IT_UTYPE: begin
        if (r_ir[6:0] == OP_AUIPC) w_a = r_pc + w_imm.u;
        else                       w_a = w_imm.u;
      end
      IT_JRTYPE: begin
        w_a    = (w_rs1 + w_imm.i) & ~32'd1;
        w_pass = r_pc + 32'd4;
      end
      default: w_known = 1'b0;
    endcase
  end

  // Issue sequencer: IDLE -> RD -> SETUP -> STROBE -> DONE -> IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_stage   <= '0;
      r_ir      <= '0;
      r_itype   <= '0;
      r_pc      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_pass    <= '0;
      r_rd_a    <= 1'b0;
      r_rd_b    <= 1'b0;
      r_rd_pass <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_stage <= stage_i;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_ir    <= ir_i;
            r_itype <= itype_i;
            r_pc    <= pc_i;
            r_state <= ST_RD;
          end
        end
        ST_RD: begin
          if (w_known) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_pass  <= w_pass;
            r_state <= ST_SETUP;
          end else begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          r_rd_a    <= 1'b1;
          r_rd_b    <= 1'b1;
          r_rd_pass <= itype_uses_pass(r_itype);
          r_state   <= ST_STROBE;
        end
        ST_STROBE: begin
          r_rd_a    <= 1'b0;
          r_rd_b    <= 1'b0;
          r_rd_pass <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign readd_a_o     = r_a;
  assign readd_b_o     = r_b;
  assign readd_pass_o  = r_pass;
  assign readin_a_o    = r_rd_a;
  assign readin_b_o    = r_rd_b;
  assign readin_pass_o = r_rd_pass;
  assign busy_o        = (r_state != ST_IDLE);
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed instruction vectors with hand-computed
// operands. The driver pushes the expected response when it raises the
// decode stage; a negedge monitor pops and compares whenever the DUT strobes
// or flags an error. Honors ISSUE_FWD_EN for the bypass vector.
module tb_operand_issue;
  import operand_issue_pkg::*;

  localparam int EW = 130; // {start_cyc[31:0], err, pass_en, a, b, pass}

  logic        clk;
  logic        reset;
  logic [2:0]  stage_i;
  logic [31:0] ir_i;
  logic [4:0]  itype_i;
  logic [31:0] pc_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic [31:0] readd_a_o, readd_b_o, readd_pass_o;
  logic        readin_a_o, readin_b_o, readin_pass_o;
  logic        busy_o, done_o, err_o;
  logic [2:0]  dbg_state_o;

  logic [31:0]   rf [32];
  logic [EW-1:0] exp_q [$];
  int            cyc;
  int            n_cmp;
  int            n_fail;
  int            last_strobe;
  logic          pending_done;

  operand_issue dut (
    .clk           (clk),
    .reset         (reset),
    .stage_i       (stage_i),
    .ir_i          (ir_i),
    .itype_i       (itype_i),
    .pc_i          (pc_i),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .wb_we_i       (wb_we_i),
    .wb_rd_i       (wb_rd_i),
    .wb_data_i     (wb_data_i),
    .readd_a_o     (readd_a_o),
    .readd_b_o     (readd_b_o),
    .readd_pass_o  (readd_pass_o),
    .readin_a_o    (readin_a_o),
    .readin_b_o    (readin_b_o),
    .readin_pass_o (readin_pass_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read register file model (x0 deliberately non-zero)
  always @(posedge clk) begin
    rs1_data_i <= rf[rs1_addr_o];
    rs2_data_i <= rf[rs2_addr_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: raise decode stage for one cycle (or hold it), push expectation
  task automatic issue(input logic [31:0] ir, input logic [4:0] it, input logic [31:0] pc,
                       input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ep,
                       input logic epen, input logic eerr, input int hold, input logic scramble);
    @(posedge clk); #1;
    ir_i    = ir;
    itype_i = it;
    pc_i    = pc;
    stage_i = 3'd2;
    exp_q.push_back({cyc[31:0], eerr, epen, ea, eb, ep});
    @(posedge clk); #1;
    if (scramble) ir_i = 32'hFFFF_FFFF;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
    end
    stage_i = 3'd3;
    repeat (6) @(posedge clk);
    #1;
    stage_i = 3'd0;
    if (!eerr) begin
      chk("hold_a", readd_a_o, ea);
      chk("hold_b", readd_b_o, eb);
      chk("hold_pass", readd_pass_o, ep);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (readin_a_o || readin_b_o || readin_pass_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe expected none (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_on_err_vector", {31'b0, e[97]}, 32'd0);
        chk("strobe_timing", cyc, e[129:98] + 32'd3);
        chk("readin_a", {31'b0, readin_a_o}, 32'd1);
        chk("readin_b", {31'b0, readin_b_o}, 32'd1);
        chk("readin_pass", {31'b0, readin_pass_o}, {31'b0, e[96]});
        chk("readd_a", readd_a_o, e[95:64]);
        chk("readd_b", readd_b_o, e[63:32]);
        chk("readd_pass", readd_pass_o, e[31:0]);
        chk("busy_in_strobe", {31'b0, busy_o}, 32'd1);
        chk("done_outstanding", {31'b0, pending_done}, 32'd0);
        pending_done = 1'b1;
        last_strobe  = cyc;
      end
    end
    if (err_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_err: got err expected none (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("err_expected", {31'b0, e[97]}, 32'd1);
        chk("err_timing", cyc, e[129:98] + 32'd2);
      end
    end
    if (done_o) begin
      chk("done_after_strobe", {31'b0, pending_done}, 32'd1);
      chk("done_timing", cyc, last_strobe + 1);
      pending_done = 1'b0;
    end
  end

  // Watchdog
  initial begin
    #200000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Main sequence
  initial begin
    logic [31:0] exp_fwd;
    n_cmp        = 0;
    n_fail       = 0;
    last_strobe  = 0;
    pending_done = 1'b0;
    reset     = 1'b0;
    stage_i   = 3'd0;
    ir_i      = 32'd0;
    itype_i   = 5'd0;
    pc_i      = 32'd0;
    wb_we_i   = 1'b0;
    wb_rd_i   = 5'd0;
    wb_data_i = 32'd0;
    for (int i = 0; i < 32; i++) rf[i] = 32'hCAFE_0000 + i;
    rf[0]  = 32'hFFFF_FFFF;
    rf[2]  = 32'd7;
    rf[3]  = 32'h0000_DEAD;
    rf[4]  = 32'h0000_0100;
    rf[5]  = 32'h0000_0203;
    rf[6]  = 32'h1111_1111;
    rf[7]  = 32'h2222_2222;
    rf[9]  = 32'h1234_5678;
    rf[11] = 32'h0000_AAAA;
    rf[12] = 32'd3;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readd_a", readd_a_o, 32'd0);
    chk("rst_readd_b", readd_b_o, 32'd0);
    chk("rst_readd_pass", readd_pass_o, 32'd0);
    chk("rst_strobes", {29'b0, readin_a_o, readin_b_o, readin_pass_o}, 32'd0);
    chk("rst_flags", {29'b0, busy_o, done_o, err_o}, 32'd0);
    chk("rst_state", {29'b0, dbg_state_o}, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // ADDI x1,x2,-5
    issue(32'hFFB1_0093, IT_ITYPE, 32'h0, 32'd7, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    // SW x3,8(x4)
    issue(32'h0032_2423, IT_STYPE, 32'h0, 32'h100, 32'd8, 32'hDEAD, 1'b1, 1'b0, 0, 1'b0);
    // BEQ x6,x7,-16 at pc 0x40
    issue(32'hFE73_08E3, IT_BTYPE, 32'h40, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0, 1'b1, 1'b0, 0, 1'b0);
    // JALR x1,4(x5) at pc 0x80, IR scrambled after start
    issue(32'h0042_80E7, IT_JRTYPE, 32'h80, 32'h206, 32'd0, 32'h84, 1'b1, 1'b0, 0, 1'b1);
    // ADD x8,x0,x9: x0 forced to zero
    issue(32'h0090_0433, IT_RTYPE, 32'h0, 32'd0, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    // SLLI x1,x2,3 and SRAI x1,x2,31: shamt zero-extended
    issue(32'h0031_1093, IT_ITYPE, 32'h0, 32'd7, 32'd3, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    issue(32'h41F1_5093, IT_ITYPE, 32'h0, 32'd7, 32'd31, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    // LW x1,-4(x2)
    issue(32'hFFC1_2083, IT_LTYPE, 32'h0, 32'd7, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    // LUI x1,0xABCDE and AUIPC x1,0x1 at pc 0x1000
    issue(32'hABCD_E0B7, IT_UTYPE, 32'h0, 32'hABCD_E000, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    issue(32'h0000_1097, IT_UTYPE, 32'h1000, 32'h2000, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0);

    // Writeback bypass on rs1 (ADD x10,x11,x12)
`ifdef ISSUE_FWD_EN
    exp_fwd = 32'h55;
`else
    exp_fwd = 32'hAAAA;
`endif
    wb_we_i   = 1'b1;
    wb_rd_i   = 5'd11;
    wb_data_i = 32'h55;
    issue(32'h00C5_8533, IT_RTYPE, 32'h0, exp_fwd, 32'd3, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    wb_we_i   = 1'b0;
    wb_rd_i   = 5'd0;
    wb_data_i = 32'd0;

    // Unsupported format: error pulse only
    issue(32'hFFB1_0093, 5'h1F, 32'h0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 0, 1'b0);

    // Decode stage held for many cycles: exactly one issue
    issue(32'hFFB1_0093, IT_ITYPE, 32'h0, 32'd7, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 12, 1'b0);

    // Reset asserted in the middle of the strobe cycle
    @(posedge clk); #1;
    ir_i    = 32'h0032_2423;
    itype_i = IT_STYPE;
    stage_i = 3'd2;
    @(posedge clk); #1;
    stage_i = 3'd3;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_rst_strobe", {31'b0, readin_a_o}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_strobes", {29'b0, readin_a_o, readin_b_o, readin_pass_o}, 32'd0);
    chk("mid_rst_readd_a", readd_a_o, 32'd0);
    chk("mid_rst_readd_pass", readd_pass_o, 32'd0);
    chk("mid_rst_busy", {31'b0, busy_o}, 32'd0);
    @(posedge clk); #1;
    reset   = 1'b1;
    stage_i = 3'd0;
    repeat (2) @(posedge clk);

    // Normal issue after reset
    issue(32'hFE73_08E3, IT_BTYPE, 32'h40, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0, 1'b1, 1'b0, 0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("done_drained", {31'b0, pending_done}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
